// File: rtl/led_frame_serializer.sv
// Serializes one NLEDS-bit frame onto din/dclk, then pulses strobe. A frame takes (2*NLEDS+1)*CLK_DIV+STROBE_LEN cycles from accept to frame_done.
// Backpressure: frame_ready is high only in IDLE, so a new frame is held off until the previous one has been latched.
module led_frame_serializer #(
  parameter int NLEDS      = 64,
  parameter int CLK_DIV    = 4,
  parameter int STROBE_LEN = 2,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NLEDS-1:0] frame_data,
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic             din,
  output logic             dclk,
  output logic             strobe,
  output logic             busy,
  output logic             frame_done
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(NLEDS + 1);
  localparam int STB_W = $clog2(STROBE_LEN + 1);

  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(NLEDS - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STROBE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SETTLE,
    ST_STROBE
  } state_t;

  state_t           state, state_nxt;
  logic [NLEDS-1:0] shreg, shreg_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic [STB_W-1:0] stb_cnt, stb_nxt;
  logic             din_nxt, dclk_nxt, strobe_nxt, done_nxt;

  logic             first_bit, next_bit;
  logic [NLEDS-1:0] shreg_adv;

  // The outgoing bit always sits at one end of shreg; the next one is its neighbour.
  assign first_bit = MSB_FIRST ? frame_data[NLEDS-1] : frame_data[0];
  assign next_bit  = MSB_FIRST ? shreg[NLEDS-2] : shreg[1];
  assign shreg_adv = MSB_FIRST ? {shreg[NLEDS-2:0], 1'b0} : {1'b0, shreg[NLEDS-1:1]};

  assign frame_ready = (state == ST_IDLE) & ~reset;
  assign busy        = (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    stb_nxt    = stb_cnt;
    din_nxt    = din;
    dclk_nxt   = dclk;
    strobe_nxt = strobe;
    done_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (frame_valid && frame_ready) begin
          state_nxt = ST_SHIFT;
          shreg_nxt = frame_data;
          din_nxt   = first_bit;
          dclk_nxt  = 1'b0;
          div_nxt   = '0;
          bit_nxt   = '0;
        end
      end

      ST_SHIFT: begin
        div_nxt = div_cnt + 1'b1;
        if (div_cnt == HALF_LAST) begin
          dclk_nxt = 1'b1;
        end
        // din only moves on the dclk falling edge, giving D cycles of setup and hold.
        if (div_cnt == BIT_LAST) begin
          dclk_nxt = 1'b0;
          div_nxt  = '0;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = ST_SETTLE;
            din_nxt   = 1'b0;
            bit_nxt   = '0;
          end else begin
            bit_nxt   = bit_cnt + 1'b1;
            shreg_nxt = shreg_adv;
            din_nxt   = next_bit;
          end
        end
      end

      ST_SETTLE: begin
        div_nxt = div_cnt + 1'b1;
        if (div_cnt == HALF_LAST) begin
          state_nxt  = ST_STROBE;
          strobe_nxt = 1'b1;
          div_nxt    = '0;
          stb_nxt    = '0;
        end
      end

      ST_STROBE: begin
        stb_nxt = stb_cnt + 1'b1;
        if (stb_cnt == STB_LAST) begin
          state_nxt  = ST_IDLE;
          strobe_nxt = 1'b0;
          done_nxt   = 1'b1;
          stb_nxt    = '0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      stb_cnt    <= '0;
      din        <= 1'b0;
      dclk       <= 1'b0;
      strobe     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
      stb_cnt    <= stb_nxt;
      din        <= din_nxt;
      dclk       <= dclk_nxt;
      strobe     <= strobe_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Bench for led_frame_serializer: an MSB-first and an LSB-first instance share stimulus,
// outputs are muxed by sel into a waveform recorder and an LED driver shift/latch model.
`timescale 1ns/1ps
module tb_led_frame_serializer;
  localparam int N      = 64;
  localparam int D      = 4;
  localparam int S      = 2;
  localparam int PERIOD = (2 * N + 1) * D + S;
  localparam int HIST   = PERIOD + 48;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] frame_data;
  logic         frame_valid;
  logic         sel;

  logic rdy_a, din_a, dclk_a, stb_a, busy_a, done_a;
  logic rdy_b, din_b, dclk_b, stb_b, busy_b, done_b;
  logic rdy_m, din_m, dclk_m, stb_m, busy_m, done_m;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  led_frame_serializer #(.NLEDS(N), .CLK_DIV(D), .STROBE_LEN(S), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid & ~sel),
    .frame_ready(rdy_a), .din(din_a), .dclk(dclk_a), .strobe(stb_a), .busy(busy_a), .frame_done(done_a)
  );

  led_frame_serializer #(.NLEDS(N), .CLK_DIV(D), .STROBE_LEN(S), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid & sel),
    .frame_ready(rdy_b), .din(din_b), .dclk(dclk_b), .strobe(stb_b), .busy(busy_b), .frame_done(done_b)
  );

  assign rdy_m  = sel ? rdy_b  : rdy_a;
  assign din_m  = sel ? din_b  : din_a;
  assign dclk_m = sel ? dclk_b : dclk_a;
  assign stb_m  = sel ? stb_b  : stb_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;

  // Driver: first bit received is pushed to the far end (position N-1) of its chain.
  logic [N-1:0] chain = '0;
  logic [N-1:0] disp  = '0;
  int           strobe_pulses = 0;
  always @(posedge dclk_m) chain <= {chain[N-2:0], din_m};
  always @(posedge stb_m) begin
    disp          <= chain;
    strobe_pulses <= strobe_pulses + 1;
  end

  logic din_h [HIST];
  logic dclk_h[HIST];
  logic stb_h [HIST];
  logic busy_h[HIST];
  logic rdy_h [HIST];

  function automatic logic model_bit(input logic [N-1:0] d, input bit msb, input int k);
    return msb ? d[N-1-k] : d[k];
  endfunction

  function automatic logic [N-1:0] model_display(input logic [N-1:0] d, input bit msb);
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[j] = msb ? d[j] : d[N-1-j];
    return r;
  endfunction

  // Counts recorded samples (t cycles after accept) that disagree with the ideal waveform.
  function automatic int wave_errors(input logic [N-1:0] d, input bit msb, input int upto);
    int   errs;
    logic e_din, e_dclk, e_stb;
    errs = 0;
    for (int t = 0; t < upto && t < HIST; t++) begin
      e_din  = 1'b0;
      e_dclk = 1'b0;
      e_stb  = 1'b0;
      if (t < 2 * N * D) begin
        e_din  = model_bit(d, msb, t / (2 * D));
        e_dclk = ((t / D) % 2) == 1;
      end else if (t >= (2 * N + 1) * D && t < (2 * N + 1) * D + S) begin
        e_stb = 1'b1;
      end
      if (din_h[t] !== e_din || dclk_h[t] !== e_dclk || stb_h[t] !== e_stb ||
          busy_h[t] !== 1'b1 || rdy_h[t] !== 1'b0) errs++;
    end
    return errs;
  endfunction

  // Offers one frame to the selected instance and records its outputs until frame_done.
  task automatic capture(input logic [N-1:0] data, input bit keep_valid, input bit swap_mid,
                         input logic [N-1:0] data_next, output int wait_cyc, output int done_t,
                         output bit ready_at_done, output bit timed_out);
    wait_cyc      = 0;
    done_t        = -1;
    ready_at_done = 1'b0;
    timed_out     = 1'b0;
    while (rdy_m !== 1'b1 && wait_cyc < 1000) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (rdy_m !== 1'b1) begin
      timed_out = 1'b1;
      return;
    end
    frame_data  = data;
    frame_valid = 1'b1;
    for (int t = 0; t < PERIOD + 40; t++) begin
      @(negedge clk);
      if (!keep_valid) frame_valid = 1'b0;
      if (swap_mid && t == 100) frame_data = data_next;
      if (t < HIST) begin
        din_h[t]  = din_m;
        dclk_h[t] = dclk_m;
        stb_h[t]  = stb_m;
        busy_h[t] = busy_m;
        rdy_h[t]  = rdy_m;
      end
      if (done_m === 1'b1) begin
        done_t        = t;
        ready_at_done = rdy_m;
        break;
      end
    end
    if (done_t < 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    sel         = 1'b0;
    repeat (3) begin
      @(negedge clk);
      nvec++;
      if ({din_a, dclk_a, stb_a, busy_a, done_a, rdy_a, din_b, dclk_b, stb_b, busy_b, done_b, rdy_b} !== 12'h000) begin
        nerr++;
        $display("FAIL reset_outputs: got %b required all zero",
                 {din_a, dclk_a, stb_a, busy_a, done_a, rdy_a, din_b, dclk_b, stb_b, busy_b, done_b, rdy_b});
      end
    end
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if ({rdy_a, rdy_b, busy_a, busy_b} !== 4'b1100) begin
      nerr++;
      $display("FAIL reset_release: ready/busy got %b required 1100", {rdy_a, rdy_b, busy_a, busy_b});
    end
  endtask

  // Shared scoring of a single recorded frame with explicit bit-order expectations.
  task automatic test_single(input bit use_lsb, input logic [N-1:0] data, input logic [N-1:0] exp_rise);
    int wc, dt, nrise, sstart, slen, werr;
    bit rad, tmo;
    logic [N-1:0] rb;
    sel = use_lsb;
    capture(data, 1'b0, 1'b0, '0, wc, dt, rad, tmo);
    nvec++;
    if (tmo) begin
      nerr++;
      $display("FAIL single%0d_timeout: no frame_done within budget", use_lsb);
    end else begin
      nrise  = 0;
      rb     = '0;
      sstart = -1;
      slen   = 0;
      for (int t = 1; t < dt; t++)
        if (dclk_h[t] && !dclk_h[t-1]) begin
          if (nrise < N) rb[nrise] = din_h[t];
          nrise++;
        end
      for (int t = 0; t < dt; t++)
        if (stb_h[t]) begin
          if (sstart < 0) sstart = t;
          slen++;
        end
      werr = wave_errors(data, !use_lsb, dt);
      nvec += 6;
      if (dt !== PERIOD) begin nerr++; $display("FAIL single%0d_done_t: got %0d required %0d", use_lsb, dt, PERIOD); end
      if (nrise !== N) begin nerr++; $display("FAIL single%0d_rises: got %0d required %0d", use_lsb, nrise, N); end
      if (rb !== exp_rise) begin nerr++; $display("FAIL single%0d_rise_bits: got %h required %h", use_lsb, rb, exp_rise); end
      if (sstart !== (2 * N + 1) * D || slen !== S) begin
        nerr++;
        $display("FAIL single%0d_strobe: start %0d len %0d required %0d len %0d", use_lsb, sstart, slen, (2 * N + 1) * D, S);
      end
      if (werr !== 0) begin nerr++; $display("FAIL single%0d_waveform: %0d bad samples required 0", use_lsb, werr); end
      if (disp !== model_display(data, !use_lsb)) begin
        nerr++;
        $display("FAIL single%0d_display: got %h required %h", use_lsb, disp, model_display(data, !use_lsb));
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int wc1, dt1, wc2, dt2, werr;
    bit rad1, rad2, tmo1, tmo2;
    logic [N-1:0] d1, d2;
    sel = 1'b0;
    d1  = {$urandom, $urandom};
    d2  = ~d1 ^ {$urandom, $urandom};
    capture(d1, 1'b1, 1'b1, d2, wc1, dt1, rad1, tmo1);
    nvec++;
    if (tmo1) begin
      nerr++;
      $display("FAIL b2b_first_timeout: no frame_done within budget");
      frame_valid = 1'b0;
    end else begin
      werr = wave_errors(d1, 1'b1, dt1);
      nvec += 4;
      if (dt1 !== PERIOD) begin nerr++; $display("FAIL b2b_first_done_t: got %0d required %0d", dt1, PERIOD); end
      if (werr !== 0) begin nerr++; $display("FAIL b2b_first_waveform: %0d bad samples required 0", werr); end
      if (rad1 !== 1'b1) begin nerr++; $display("FAIL b2b_ready_at_done: got %b required 1", rad1); end
      if (disp !== d1) begin nerr++; $display("FAIL b2b_first_display: got %h required %h", disp, d1); end
      capture(d2, 1'b0, 1'b0, '0, wc2, dt2, rad2, tmo2);
      nvec++;
      if (tmo2) begin
        nerr++;
        $display("FAIL b2b_second_timeout: no frame_done within budget");
      end else begin
        werr = wave_errors(d2, 1'b1, dt2);
        nvec += 4;
        if (wc2 !== 0) begin nerr++; $display("FAIL b2b_gap: waited %0d cycles required 0", wc2); end
        if (dt2 !== PERIOD) begin nerr++; $display("FAIL b2b_second_done_t: got %0d required %0d", dt2, PERIOD); end
        if (werr !== 0) begin nerr++; $display("FAIL b2b_second_waveform: %0d bad samples required 0", werr); end
        if (disp !== d2) begin nerr++; $display("FAIL b2b_second_display: got %h required %h", disp, d2); end
      end
    end
  endtask

  task automatic test_reset_abort();
    int   pulses0, rises, cyc, seen;
    logic prev;
    logic [N-1:0] disp0;
    sel     = 1'b0;
    pulses0 = strobe_pulses;
    disp0   = disp;
    rises   = 0;
    cyc     = 0;
    seen    = 0;
    prev    = dclk_m;
    frame_data  = {$urandom, $urandom};
    frame_valid = 1'b1;
    while (rises < 30 && cyc < 600) begin
      @(negedge clk);
      frame_valid = 1'b0;
      if (dclk_m && !prev) rises++;
      prev = dclk_m;
      cyc++;
    end
    nvec++;
    if (rises !== 30) begin
      nerr++;
      $display("FAIL abort_reach_edge30: got %0d rises required 30", rises);
    end
    reset = 1'b1;
    @(negedge clk);
    nvec++;
    if ({dclk_a, din_a, stb_a, busy_a, rdy_a, done_a} !== 6'b000000) begin
      nerr++;
      $display("FAIL abort_outputs: dclk/din/strobe/busy/ready/done got %b required 000000",
               {dclk_a, din_a, stb_a, busy_a, rdy_a, done_a});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (stb_a || done_a || busy_a) seen++;
    end
    nvec += 3;
    if (seen !== 0) begin nerr++; $display("FAIL abort_quiet: %0d active cycles required 0", seen); end
    if (strobe_pulses !== pulses0) begin
      nerr++;
      $display("FAIL abort_strobe_count: got %0d required %0d", strobe_pulses, pulses0);
    end
    if (disp !== disp0) begin nerr++; $display("FAIL abort_display: got %h required %h", disp, disp0); end
  endtask

  task automatic test_checkerboard();
    int wc, dt;
    bit rad, tmo;
    logic [N-1:0] d;
    sel = 1'b0;
    d   = 64'hAA55_AA55_AA55_AA55;
    capture(d, 1'b0, 1'b0, '0, wc, dt, rad, tmo);
    nvec++;
    if (tmo) begin
      nerr++;
      $display("FAIL checker_timeout: no frame_done within budget");
    end else begin
      nvec += 2;
      if (dt !== PERIOD) begin nerr++; $display("FAIL checker_done_t: got %0d required %0d", dt, PERIOD); end
      if (disp !== d) begin nerr++; $display("FAIL checker_display: got %h required %h", disp, d); end
    end
  endtask

  task automatic test_random();
    int wc, dt, werr;
    bit rad, tmo, lsb;
    logic [N-1:0] d;
    for (int i = 0; i < 8; i++) begin
      lsb = 1'($urandom_range(0, 1));
      sel = lsb;
      d   = {$urandom, $urandom};
      repeat ($urandom_range(0, 4)) @(negedge clk);
      capture(d, 1'b0, 1'b0, '0, wc, dt, rad, tmo);
      nvec++;
      if (tmo) begin
        nerr++;
        $display("FAIL random%0d_timeout: no frame_done within budget", i);
      end else begin
        werr = wave_errors(d, !lsb, dt);
        nvec += 3;
        if (dt !== PERIOD) begin nerr++; $display("FAIL random%0d_done_t: got %0d required %0d", i, dt, PERIOD); end
        if (werr !== 0) begin nerr++; $display("FAIL random%0d_waveform: %0d bad samples required 0", i, werr); end
        if (disp !== model_display(d, !lsb)) begin
          nerr++;
          $display("FAIL random%0d_display: got %h required %h", i, disp, model_display(d, !lsb));
        end
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    test_single(1'b1, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0003);
    test_back_to_back();
    test_reset_abort();
    test_checkerboard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
